// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter that shares one WIDTH-bit valid/ready output channel
//   among four requesters. A grant is held for a burst of up to MAX_BURST
//   transfers, then priority rotates to the index after the granted one.
//   The registered grant index is exported so other 4:1 muxes can follow it.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   req        in   [3:0]        request per requester
//   din        in   [4*WIDTH-1:0] requester data, slice i = requester i
//   out_ready  in   consumer accepts the current beat
//   out_valid  out  output beat valid
//   out_data   out  [WIDTH-1:0] din slice selected by sel
//   ack        out  [3:0] one-hot, set in the cycle requester i's beat transfers
//   sel        out  [1:0] registered grant index
//   busy       out  high while a grant is active
module rr_mux_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   din,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [3:0]           ack,
    output logic [1:0]           sel,
    output logic                 busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Count value of the last beat in a burst.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    logic [0:0]       state_r;
    logic [1:0]       ptr_r;
    logic [1:0]       sel_r;
    logic [CNT_W-1:0] cnt_r;

    logic [0:0]       state_nxt_s;
    logic [1:0]       ptr_nxt_s;
    logic [1:0]       sel_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic             in_grant_s;
    logic             req_sel_s;
    logic             transfer_s;

    // First set request bit scanning upward from the priority pointer (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = p;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = p + 2'(k);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                pick  = pick;
            end
        end
        return pick;
    endfunction

    assign in_grant_s = (state_r == ST_GRANT);
    assign req_sel_s  = req[sel_r];
    assign transfer_s = in_grant_s & req_sel_s & out_ready;

    // Next-state logic: IDLE picks a winner, GRANT counts beats and releases.
    always_comb begin
        state_nxt_s = state_r;
        ptr_nxt_s   = ptr_r;
        sel_nxt_s   = sel_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    sel_nxt_s   = rr_pick(req, ptr_r);
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // A dropped request or the final beat of a burst both release.
                if (!req_sel_s || (transfer_s && (cnt_r == CNT_LAST))) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    ptr_nxt_s   = sel_r + 2'd1;
                end else if (transfer_s) begin
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end else begin
                    cnt_nxt_s   = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Arbiter state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= 2'd0;
            sel_r   <= 2'd0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            ptr_r   <= ptr_nxt_s;
            sel_r   <= sel_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Data mux steered by the registered grant index in every state.
    always_comb begin
        case (sel_r)
            2'd0:    out_data = din[WIDTH-1:0];
            2'd1:    out_data = din[2*WIDTH-1:WIDTH];
            2'd2:    out_data = din[3*WIDTH-1:2*WIDTH];
            2'd3:    out_data = din[4*WIDTH-1:3*WIDTH];
            default: out_data = din[WIDTH-1:0];
        endcase
    end

    assign out_valid = in_grant_s & req_sel_s;
    assign ack       = transfer_s ? (4'b0001 << sel_r) : 4'b0000;
    assign sel       = sel_r;
    assign busy      = in_grant_s;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [3:0]         req;
    logic [4*WIDTH-1:0] din;
    logic               out_ready;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic [3:0]         ack;
    logic [1:0]         sel;
    logic               busy;

    int errors = 0;
    int checks = 0;
    int beats  = 0;
    int exp_sel;
    logic [7:0] dv [4];
    logic [5:0] bp;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .din       (din),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ack       (ack),
        .sel       (sel),
        .busy      (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic outs(input string tag, input logic v, input logic [3:0] a,
                        input logic [1:0] s, input logic b, input logic [7:0] d);
        chk({tag, ".valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".ack"},   32'(ack),       32'(a));
        chk({tag, ".sel"},   32'(sel),       32'(s));
        chk({tag, ".busy"},  32'(busy),      32'(b));
        chk({tag, ".data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        dv[0] = 8'h11; dv[1] = 8'h33; dv[2] = 8'hA5; dv[3] = 8'h44;
        din       = {dv[3], dv[2], dv[1], dv[0]};
        reset     = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b0;
        #3;
        outs("reset", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h11);
        tick();
        reset = 1'b0;

        // Single requester: four beats on 2, one bubble, regrant to 2.
        req = 4'b0100; out_ready = 1'b1;
        #1 outs("single.idle", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h11);
        tick();
        for (int i = 0; i < 4; i++) begin
            #1 outs("single.beat", 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA5);
            tick();
        end
        #1 outs("single.bubble", 1'b0, 4'b0000, 2'd2, 1'b0, 8'hA5);
        tick();
        #1 outs("single.regrant", 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA5);
        req = 4'b0000;
        #1 outs("single.drop", 1'b0, 4'b0000, 2'd2, 1'b1, 8'hA5);
        tick();
        #1 outs("single.release", 1'b0, 4'b0000, 2'd2, 1'b0, 8'hA5);

        // Async reset between edges returns ptr to 0.
        reset = 1'b1;
        #1 outs("reset2", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h11);
        reset = 1'b0;

        // Full contention: order 0,1,2,3,0, 4 beats each, one bubble between.
        req = 4'b1111; out_ready = 1'b1;
        for (int c = 0; c < 25; c++) begin
            #1;
            if ((c % 5) == 0) begin
                exp_sel = (c == 0) ? 0 : (((c / 5) - 1) % 4);
                outs("contention.bubble", 1'b0, 4'b0000, 2'(exp_sel), 1'b0, dv[exp_sel]);
            end else begin
                exp_sel = (c / 5) % 4;
                outs("contention.beat", 1'b1, 4'(4'b0001 << exp_sel), 2'(exp_sel), 1'b1, dv[exp_sel]);
            end
            if (ack != 4'b0000) beats++;
            tick();
        end
        chk("contention.beats", 32'(beats), 32'd20);

        // Backpressure on requester 1: acks only on ready cycles.
        req = 4'b0010; out_ready = 1'b0;
        #1 outs("bp.idle", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h11);
        tick();
        bp = 6'b111001;
        for (int i = 0; i < 6; i++) begin
            out_ready = bp[i];
            #1 outs("bp.beat", 1'b1, bp[i] ? 4'b0010 : 4'b0000, 2'd1, 1'b1, 8'h33);
            tick();
        end
        #1 outs("bp.release", 1'b0, 4'b0000, 2'd1, 1'b0, 8'h33);

        // Early drop on requester 3 after two beats, then grant goes to 0.
        req = 4'b1000; out_ready = 1'b1;
        tick();
        #1 outs("drop.beat0", 1'b1, 4'b1000, 2'd3, 1'b1, 8'h44);
        tick();
        #1 outs("drop.beat1", 1'b1, 4'b1000, 2'd3, 1'b1, 8'h44);
        tick();
        req = 4'b0000;
        #1 outs("drop.cleared", 1'b0, 4'b0000, 2'd3, 1'b1, 8'h44);
        tick();
        #1 outs("drop.release", 1'b0, 4'b0000, 2'd3, 1'b0, 8'h44);
        req = 4'b1001;
        tick();
        #1 outs("drop.next", 1'b1, 4'b0001, 2'd0, 1'b1, 8'h11);
        req = 4'b0000;
        tick();
        #1 outs("drop.idle", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h11);

        // Priority wrap: ptr=3 after grant on 2, req 0011 goes to 0.
        req = 4'b0100;
        tick();
        #1 outs("wrap.grant2", 1'b1, 4'b0100, 2'd2, 1'b1, 8'hA5);
        req = 4'b0011;
        #1 outs("wrap.drop2", 1'b0, 4'b0000, 2'd2, 1'b1, 8'hA5);
        tick();
        #1 outs("wrap.bubble", 1'b0, 4'b0000, 2'd2, 1'b0, 8'hA5);
        tick();
        #1 outs("wrap.grant0", 1'b1, 4'b0001, 2'd0, 1'b1, 8'h11);
        req = 4'b0000;
        tick();
        #1 outs("wrap.idle", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h11);

        // Async reset mid-burst at cnt=2, then a fresh full burst on 1.
        req = 4'b0010; out_ready = 1'b1;
        tick();
        tick();
        tick();
        #1 outs("areset.cnt2", 1'b1, 4'b0010, 2'd1, 1'b1, 8'h33);
        #2 reset = 1'b1;
        #1 outs("areset.during", 1'b0, 4'b0000, 2'd0, 1'b0, 8'h11);
        reset = 1'b0;
        tick();
        for (int k = 0; k < 4; k++) begin
            #1 outs("areset.burst", 1'b1, 4'b0010, 2'd1, 1'b1, 8'h33);
            tick();
        end
        #1 outs("areset.release", 1'b0, 4'b0000, 2'd1, 1'b0, 8'h33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Round-robin arbiter that shares one WIDTH-bit output channel among four requesters by driving the select of a 4:1 multiplexer. It holds a grant for a burst of up to MAX_BURST transfers, then rotates priority. It sits between four producer ports and a single valid/ready consumer, and exports the registered select so the same select can steer other 4:1 muxes.

## Interface
- WIDTH, 8, data bits per requester
- MAX_BURST, 4, maximum transfers per grant (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  4  request per requester; bit i = requester i has data
- din  in  4*WIDTH  requester data; din[i*WIDTH +: WIDTH] belongs to requester i
- out_ready  in  1  consumer accepts the current beat
- out_valid  out  1  output beat valid
- out_data  out  WIDTH  muxed data, din slice selected by sel
- ack  out  4  one-hot; ack[i]=1 in the cycle requester i's beat transfers
- sel  out  2  registered grant index (mux select)
- busy  out  1  1 while in GRANT

## Operation
- Registers: state {IDLE, GRANT}, ptr[1:0] (priority start), sel[1:0], cnt (clog2(MAX_BURST+1) bits).
- Transfer = GRANT & req[sel] & out_ready.
- IDLE:
  - If req != 0, scan indices ptr, ptr+1, ptr+2, ptr+3 (mod 4); first set bit → sel. cnt←0. Next state GRANT.
  - If req == 0, stay IDLE; sel holds.
- GRANT:
  - out_valid = req[sel]; out_data = din[sel]; ack[sel] = transfer; other ack bits 0.
  - On a transfer with cnt+1 < MAX_BURST: cnt←cnt+1, stay GRANT.
  - On a transfer with cnt+1 == MAX_BURST: release.
  - If req[sel]==0: no transfer, release (early drop ends burst).
  - Release: state←IDLE, cnt←0, ptr←sel+1 (3 wraps to 0).
- out_valid, ack, busy are combinational from the registered state/sel and current inputs; no combinational path from req to sel.
- out_data = din[sel] in every state; it is meaningful only when out_valid=1.
- req[j] for j≠sel is ignored during GRANT; it is considered at the next IDLE.
- Requesters must hold din stable while req is high and ack is low.

## Timing
- Reset (async, immediate): state=IDLE, ptr=0, sel=0, cnt=0; out_valid=0, ack=0, busy=0, out_data=din[0].
- Grant latency: req seen in IDLE at edge N → GRANT, sel valid, out_valid=1 from cycle N+1.
- One mandatory IDLE bubble after every release; back-to-back bursts from different requesters are separated by exactly 1 cycle.
- Backpressure: out_ready=0 in GRANT → no transfer, cnt unchanged, grant held indefinitely while req[sel]=1.
- Max throughput with continuous requests: MAX_BURST beats per MAX_BURST+1 cycles.
- MAX_BURST=1: every transfer releases; pure per-beat round robin.
- Simultaneous final transfer and req drop in the next cycle: no effect; release already occurred on the transfer.
- reset asserted mid-burst: outputs clear in the same cycle; the partial burst is abandoned and ptr returns to 0.

## Test plan
- Single requester: req=4'b0100, out_ready=1, din[2]=8'hA5 → sel=2 at cycle 1, four acks on ack[2] carrying 8'hA5, release, 1 IDLE cycle, regrant to 2.
- Full contention: req=4'hF held, out_ready=1, MAX_BURST=4 → grant order 0,1,2,3,0; 4 beats each, 1 bubble between bursts; 20 beats in 25 cycles.
- Backpressure: grant to 1, out_ready toggles 1,0,0,1,1,1 → ack[1] only on ready cycles; burst ends after the 4th ack, so cnt freezes during stalls.
- Early drop: req[3] held for 2 transfers then cleared → release after 2 acks, ptr=0; next grant goes to 0 when req=4'b1001.
- Priority wrap: ptr=3 after burst on 2, req=4'b0011 → grant 0, not 1.
- Async reset mid-burst: assert reset between edges during cnt=2 → out_valid, ack, busy drop immediately; after deassert, req=4'b0010 → grant to 1 one cycle later with cnt=0.
